// File: rtl/pr3_pkg.sv
// Shared types and constants for the peak detector: Q3.13 phase type,
// the +/-pi wrap constants and the run FSM encoding.
package pr3_pkg;

   typedef logic signed [15:0] phase_t;

   localparam logic signed [16:0] PHASE_PI  = 17'sd25736;
   localparam logic signed [16:0] PHASE_2PI = 17'sd51472;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SEARCH  = 2'd1,
      CAPTURE = 2'd2,
      EMIT    = 2'd3
   } state_t;

endpackage

// File: rtl/phase_wrap.sv
// Combinational Q3.13 phase difference ph_i - ref_i, wrapped into (-pi, pi].
module phase_wrap
   import pr3_pkg::*;
(
   input  logic [15:0] ph_i,
   input  logic [15:0] ref_i,
   output logic [15:0] diff_o
);

   logic signed [16:0] raw_s;
   logic signed [16:0] wrap_s;

   // 17-bit difference so two full-range phases never overflow before the wrap.
   always_comb begin
      raw_s = $signed({ph_i[15], ph_i}) - $signed({ref_i[15], ref_i});
      if (raw_s > PHASE_PI) begin
         wrap_s = raw_s - PHASE_2PI;
      end else if (raw_s <= -PHASE_PI) begin
         wrap_s = raw_s + PHASE_2PI;
      end else begin
         wrap_s = raw_s;
      end
   end

   assign diff_o = 16'(wrap_s);

endmodule

// File: rtl/peak_detect.sv
// Finds the strongest positive-frequency bin of antenna 0 in each run of NSINK
// spectra, captures the other antennas' phase at that bin and emits one result.
module peak_detect
   import pr3_pkg::*;
#(
   parameter int NSINK  = 3,
   parameter int FFT    = 11,
   parameter int MWIDTH = 25,
   parameter int MINBIN = 1,
   parameter int BIN_HZ = 9766
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              sink_valid,
   input  logic              sink_sop,
   input  logic              sink_eop,
   input  logic [MWIDTH-1:0] sink_mag,
   input  logic [15:0]       sink_phase,
   output logic              source_valid,
   output logic [FFT-1:0]    source_bin,
   output logic [MWIDTH-1:0] source_mag,
   output logic [23:0]       source_freq,
   output logic [15:0]       source_phaseA,
   output logic [15:0]       source_phaseB,
   output logic              error
);

   localparam int CW = $clog2(NSINK);
   localparam int PW = FFT + 24;
   localparam logic [FFT-1:0] LAST_BIN = {FFT{1'b1}};
   localparam logic [FFT-1:0] MIN_BIN  = FFT'(MINBIN);
   localparam logic [FFT-1:0] HALF_BIN = FFT'(2 ** (FFT - 1));
   localparam logic [PW-1:0]  FREQ_MAX = PW'({24{1'b1}});

   state_t            state_q, state_d;
   logic [FFT-1:0]    bin_q, bin_d;
   logic [CW-1:0]     ch_q, ch_d;
   logic [MWIDTH-1:0] best_mag_q, best_mag_d;
   logic [FFT-1:0]    best_bin_q, best_bin_d;
   logic [15:0]       ph0_q, ph0_d;
   logic [15:0]       ph1_q, ph1_d;
   logic [15:0]       ph2_q, ph2_d;

   logic              st_vld_q, st_vld_d;
   logic [FFT-1:0]    st_bin_q, st_bin_d;
   logic [MWIDTH-1:0] st_mag_q, st_mag_d;
   logic [23:0]       st_freq_q, st_freq_d;
   logic [15:0]       st_pha_q, st_pha_d;
   logic [15:0]       st_phb_q, st_phb_d;

   logic              src_vld_q, src_vld_d;
   logic [FFT-1:0]    src_bin_q, src_bin_d;
   logic [MWIDTH-1:0] src_mag_q, src_mag_d;
   logic [23:0]       src_freq_q, src_freq_d;
   logic [15:0]       src_pha_q, src_pha_d;
   logic [15:0]       src_phb_q, src_phb_d;
   logic              err_q, err_d;

   logic [FFT-1:0]    cur_bin_s;
   logic              restart_s;
   logic [PW-1:0]     prod_s;
   logic [23:0]       freq_s;
   logic [15:0]       diff_a_s;
   logic [15:0]       diff_b_s;

   phase_wrap u_wrap_a (
      .ph_i   (ph1_q),
      .ref_i  (ph0_q),
      .diff_o (diff_a_s)
   );

   phase_wrap u_wrap_b (
      .ph_i   (ph2_q),
      .ref_i  (ph0_q),
      .diff_o (diff_b_s)
   );

   assign prod_s = PW'(best_bin_q) * PW'(BIN_HZ);
   assign freq_s = (prod_s > FREQ_MAX) ? 24'hFF_FFFF : prod_s[23:0];

   // Next-state logic: EMIT snapshot, then the current beat (restart first, then search/capture, then framing).
   always_comb begin
      state_d    = state_q;
      bin_d      = bin_q;
      ch_d       = ch_q;
      best_mag_d = best_mag_q;
      best_bin_d = best_bin_q;
      ph0_d      = ph0_q;
      ph1_d      = ph1_q;
      ph2_d      = ph2_q;
      st_vld_d   = 1'b0;
      st_bin_d   = st_bin_q;
      st_mag_d   = st_mag_q;
      st_freq_d  = st_freq_q;
      st_pha_d   = st_pha_q;
      st_phb_d   = st_phb_q;
      src_vld_d  = 1'b0;
      src_bin_d  = src_bin_q;
      src_mag_d  = src_mag_q;
      src_freq_d = src_freq_q;
      src_pha_d  = src_pha_q;
      src_phb_d  = src_phb_q;
      err_d      = 1'b0;
      cur_bin_s  = bin_q;
      restart_s  = 1'b0;

      if (st_vld_q) begin
         src_vld_d  = 1'b1;
         src_bin_d  = st_bin_q;
         src_mag_d  = st_mag_q;
         src_freq_d = st_freq_q;
         src_pha_d  = st_pha_q;
         src_phb_d  = st_phb_q;
      end else begin
         src_vld_d  = 1'b0;
      end

      if (state_q == EMIT) begin
         st_vld_d  = 1'b1;
         st_bin_d  = best_bin_q;
         st_mag_d  = best_mag_q;
         st_freq_d = freq_s;
         st_pha_d  = diff_a_s;
         st_phb_d  = diff_b_s;
         state_d   = IDLE;
      end else begin
         st_vld_d  = 1'b0;
      end

      // The only legal sop inside a run is the first beat of a capture spectrum.
      if (sink_valid && sink_sop) begin
         cur_bin_s = '0;
         restart_s = !((state_q == CAPTURE) && (bin_q == '0));
         err_d     = (state_q == SEARCH) || ((state_q == CAPTURE) && (bin_q != '0));
      end else begin
         cur_bin_s = bin_q;
         restart_s = 1'b0;
      end

      if (restart_s) begin
         state_d    = SEARCH;
         ch_d       = '0;
         best_mag_d = '0;
         best_bin_d = MIN_BIN;
         ph0_d      = '0;
         ph1_d      = '0;
         ph2_d      = '0;
      end else begin
         ch_d       = ch_q;
      end

      if (sink_valid && ((state_d == SEARCH) || (state_d == CAPTURE))) begin
         case (state_d)
            SEARCH: begin
               if ((cur_bin_s >= MIN_BIN) && (cur_bin_s < HALF_BIN) && (sink_mag > best_mag_d)) begin
                  best_mag_d = sink_mag;
                  best_bin_d = cur_bin_s;
                  ph0_d      = sink_phase;
               end else begin
                  best_bin_d = best_bin_d;
               end
            end
            CAPTURE: begin
               if (cur_bin_s == best_bin_d) begin
                  case (ch_d)
                     CW'(1):  ph1_d = sink_phase;
                     CW'(2):  ph2_d = sink_phase;
                     default: ph1_d = ph1_d;
                  endcase
               end else begin
                  ph1_d = ph1_d;
               end
            end
            default: state_d = state_d;
         endcase

         if (sink_eop) begin
            bin_d = '0;
            if (cur_bin_s != LAST_BIN) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else if (state_d == SEARCH) begin
               state_d = CAPTURE;
               ch_d    = CW'(1);
            end else if (ch_d == CW'(NSINK - 1)) begin
               state_d = EMIT;
            end else begin
               ch_d    = ch_d + 1'b1;
            end
         end else if (cur_bin_s == LAST_BIN) begin
            bin_d   = '0;
            err_d   = 1'b1;
            state_d = IDLE;
         end else begin
            bin_d   = cur_bin_s + 1'b1;
         end
      end else begin
         bin_d = bin_q;
      end
   end

   // All state, result stage and output registers; synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         bin_q      <= '0;
         ch_q       <= '0;
         best_mag_q <= '0;
         best_bin_q <= MIN_BIN;
         ph0_q      <= '0;
         ph1_q      <= '0;
         ph2_q      <= '0;
         st_vld_q   <= 1'b0;
         st_bin_q   <= '0;
         st_mag_q   <= '0;
         st_freq_q  <= '0;
         st_pha_q   <= '0;
         st_phb_q   <= '0;
         src_vld_q  <= 1'b0;
         src_bin_q  <= '0;
         src_mag_q  <= '0;
         src_freq_q <= '0;
         src_pha_q  <= '0;
         src_phb_q  <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         bin_q      <= bin_d;
         ch_q       <= ch_d;
         best_mag_q <= best_mag_d;
         best_bin_q <= best_bin_d;
         ph0_q      <= ph0_d;
         ph1_q      <= ph1_d;
         ph2_q      <= ph2_d;
         st_vld_q   <= st_vld_d;
         st_bin_q   <= st_bin_d;
         st_mag_q   <= st_mag_d;
         st_freq_q  <= st_freq_d;
         st_pha_q   <= st_pha_d;
         st_phb_q   <= st_phb_d;
         src_vld_q  <= src_vld_d;
         src_bin_q  <= src_bin_d;
         src_mag_q  <= src_mag_d;
         src_freq_q <= src_freq_d;
         src_pha_q  <= src_pha_d;
         src_phb_q  <= src_phb_d;
         err_q      <= err_d;
      end
   end

   assign source_valid  = src_vld_q;
   assign source_bin    = src_bin_q;
   assign source_mag    = src_mag_q;
   assign source_freq   = src_freq_q;
   assign source_phaseA = src_pha_q;
   assign source_phaseB = src_phb_q;
   assign error         = err_q;

endmodule
